// File: rtl/wb_burst_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_burst_sched_pkg
// Description : Shared Wishbone cycle-type / burst-type codes, scheduler
//               state encoding and the burst-length helper.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_burst_sched_pkg;

    // Wishbone cycle type identifiers
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    // Wishbone burst type extensions
    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;

    // Scheduler state encoding
    localparam int              ST_W     = 3;
    localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [ST_W-1:0] ST_INIT  = 3'd1;
    localparam logic [ST_W-1:0] ST_PRIME = 3'd2;
    localparam logic [ST_W-1:0] ST_BURST = 3'd3;
    localparam logic [ST_W-1:0] ST_DONE  = 3'd4;

    // Number of beats a burst carries. Single-beat cycle types win over bte;
    // a linear burst runs to the end of the 16-word window, so adr=0 gives 16.
    function automatic logic [4:0] beat_count(input logic [2:0] cti,
                                              input logic [1:0] bte,
                                              input logic [3:0] adr);
        logic [4:0] n;
        if ((cti == CTI_CLASSIC) || (cti == CTI_EOB)) begin
            n = 5'd1;
        end else begin
            case (bte)
                BTE_WRAP4:  n = 5'd4;
                BTE_WRAP8:  n = 5'd8;
                BTE_WRAP16: n = 5'd16;
                default:    n = 5'd16 - {1'b0, adr};
            endcase
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_burst_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_burst_sched_rr_arbiter
// Description : Combinational round-robin arbiter. Grants the first
//               requester at or after the pointer, wrapping modulo NPORTS.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_burst_sched_rr_arbiter #(
    parameter int NPORTS = 4,
    parameter int PW     = 2
) (
    input  logic [NPORTS-1:0] i_req,
    input  logic [PW-1:0]     i_ptr,
    output logic [NPORTS-1:0] o_gnt
);

    logic w_found;

    // Scan offsets 0..NPORTS-1 from the pointer; the first hit wins.
    always_comb begin
        o_gnt   = '0;
        w_found = 1'b0;
        for (int i = 0; i < NPORTS; i++) begin
            for (int k = 0; k < NPORTS; k++) begin
                if (!w_found && i_req[k] && (k == ((int'(i_ptr) + i) % NPORTS))) begin
                    o_gnt[k] = 1'b1;
                    w_found  = 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_burst_sched.sv
`default_nettype none
// ============================================================================
// Module      : wb_burst_sched
// Description : Round-robin scheduler sharing one burst address generator
//               and its SDRAM datapath among up to four Wishbone requesters.
//               Latches the winner's adr/cti/bte, pulses init, turns beat
//               completions into inc/ack and cross-checks the done flag.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_burst_sched
    import wb_burst_sched_pkg::*;
#(
    parameter int NPORTS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NPORTS-1:0]     req_i,
    input  logic [4*NPORTS-1:0]   adr_i,
    input  logic [3*NPORTS-1:0]   cti_i,
    input  logic [2*NPORTS-1:0]   bte_i,
    output logic [NPORTS-1:0]     gnt_o,
    output logic [NPORTS-1:0]     ack_o,
    output logic [3:0]            adr_o,
    output logic [2:0]            cti_o,
    output logic [1:0]            bte_o,
    output logic                  init_o,
    output logic                  inc_o,
    input  logic                  beat_i,
    input  logic                  done_i,
    output logic                  busy_o,
    output logic                  err_o
);

    localparam int c_PTR_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    logic [ST_W-1:0]    r_state;
    logic [ST_W-1:0]    w_state_next;
    logic [c_PTR_W-1:0] r_ptr;
    logic [c_PTR_W-1:0] w_ptr_next;
    logic [c_PTR_W-1:0] w_win;
    logic [NPORTS-1:0]  w_arb_gnt;
    logic [NPORTS-1:0]  r_gnt;
    logic [3:0]         r_adr;
    logic [2:0]         r_cti;
    logic [1:0]         r_bte;
    logic [3:0]         w_sel_adr;
    logic [2:0]         w_sel_cti;
    logic [1:0]         w_sel_bte;
    logic [4:0]         r_cnt;
    logic               r_abort;
    logic               r_err;
    logic               w_req_any;
    logic               w_req_held;
    logic               w_beat;
    logic               w_last_beat;

    wb_burst_sched_rr_arbiter #(
        .NPORTS (NPORTS),
        .PW     (c_PTR_W)
    ) u_arb (
        .i_req  (req_i),
        .i_ptr  (r_ptr),
        .o_gnt  (w_arb_gnt)
    );

    // Turn the one-hot winner into an index and pick out its request fields.
    always_comb begin
        w_win     = '0;
        w_sel_adr = '0;
        w_sel_cti = '0;
        w_sel_bte = '0;
        for (int k = 0; k < NPORTS; k++) begin
            if (w_arb_gnt[k]) begin
                w_win     = c_PTR_W'(k);
                w_sel_adr = adr_i[4*k +: 4];
                w_sel_cti = cti_i[3*k +: 3];
                w_sel_bte = bte_i[2*k +: 2];
            end
        end
        w_ptr_next = (int'(w_win) == NPORTS - 1) ? '0 : w_win + c_PTR_W'(1);
    end

    assign w_req_any   = |req_i;
    assign w_req_held  = |(req_i & r_gnt);
    assign w_beat      = (r_state == ST_BURST) & beat_i;
    assign w_last_beat = w_beat & (r_cnt == 5'd1);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; a requester dropping out ends the burst early.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_req_any) w_state_next = ST_INIT;
            ST_INIT:  w_state_next = ST_PRIME;
            ST_PRIME: w_state_next = ST_BURST;
            ST_BURST: if (w_last_beat || !w_req_held) w_state_next = ST_DONE;
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Grant, pointer, latched request fields and the beat counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gnt   <= '0;
            r_ptr   <= '0;
            r_adr   <= '0;
            r_cti   <= '0;
            r_bte   <= '0;
            r_cnt   <= '0;
            r_abort <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req_any) begin
                        r_gnt <= w_arb_gnt;
                        r_adr <= w_sel_adr;
                        r_cti <= w_sel_cti;
                        r_bte <= w_sel_bte;
                        r_ptr <= w_ptr_next;
                    end
                end
                ST_INIT: begin
                    r_cnt   <= beat_count(r_cti, r_bte, r_adr);
                    r_abort <= 1'b0;
                end
                ST_BURST: begin
                    if (w_beat) begin
                        r_cnt <= r_cnt - 5'd1;
                    end
                    if (w_state_next == ST_DONE) begin
                        r_gnt   <= '0;
                        r_abort <= !w_last_beat;
                    end
                end
                default: ;
            endcase
        end
    end

    // Sticky error: generator claims done too early, or is not done at the end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            if ((r_state == ST_BURST) && done_i && (r_cnt > 5'd1) && (r_cti != CTI_CLASSIC)) begin
                r_err <= 1'b1;
            end
            if ((r_state == ST_DONE) && !r_abort && !done_i) begin
                r_err <= 1'b1;
            end
        end
    end

    assign gnt_o  = r_gnt;
    assign ack_o  = w_beat ? r_gnt : '0;
    assign inc_o  = w_beat;
    assign init_o = (r_state == ST_INIT);
    assign busy_o = (r_state == ST_INIT) || (r_state == ST_PRIME) || (r_state == ST_BURST);
    assign adr_o  = r_adr;
    assign cti_o  = r_cti;
    assign bte_o  = r_bte;
    assign err_o  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_wb_burst_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_burst_sched
// Description : Self-checking bench for wb_burst_sched with a burst-level
//               reference model and directed scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_burst_sched;

    localparam int N = 4;

    logic           clk    = 1'b0;
    logic           rst    = 1'b1;
    logic [N-1:0]   req_i  = '0;
    logic [4*N-1:0] adr_i  = '0;
    logic [3*N-1:0] cti_i  = '0;
    logic [2*N-1:0] bte_i  = '0;
    logic           beat_i = 1'b0;
    logic           done_i = 1'b0;
    logic [N-1:0]   gnt_o, ack_o;
    logic [3:0]     adr_o;
    logic [2:0]     cti_o;
    logic [1:0]     bte_o;
    logic           init_o, inc_o, busy_o, err_o;

    wb_burst_sched #(.NPORTS(N)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .adr_i(adr_i), .cti_i(cti_i),
        .bte_i(bte_i), .gnt_o(gnt_o), .ack_o(ack_o), .adr_o(adr_o),
        .cti_o(cti_o), .bte_o(bte_o), .init_o(init_o), .inc_o(inc_o),
        .beat_i(beat_i), .done_i(done_i), .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (burst level) ----------------
    // m_tick counts cycles since the grant was taken: 0 = init pulse,
    // 1 = generator priming, 2+ = beats accepted. m_tail marks the single
    // closing cycle after a burst.
    int         m_owner = 0, m_ptr = 0, m_tick = 0, m_left = 0, m_win = 0, m_p = 0;
    bit         m_active = 0, m_tail = 0, m_abort = 0, m_err = 0;
    logic [3:0] m_adr = '0;
    logic [2:0] m_cti = '0;
    logic [1:0] m_bte = '0;

    function automatic int beats(input logic [2:0] c, input logic [1:0] b, input logic [3:0] a);
        if (c == 3'b000 || c == 3'b111) return 1;
        if (b == 2'b01) return 4;
        if (b == 2'b10) return 8;
        if (b == 2'b11) return 16;
        return 16 - int'(a);
    endfunction

    // Advance the model one clock, or clear it on reset.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 0; m_tail = 0; m_abort = 0; m_err = 0;
            m_owner = 0; m_ptr = 0; m_tick = 0; m_left = 0;
            m_adr = '0; m_cti = '0; m_bte = '0;
        end else if (m_tail) begin
            if (!m_abort && !done_i) m_err = 1;
            m_tail = 0;
            m_active = 0;
        end else if (m_active) begin
            if (m_tick >= 2) begin
                if (done_i && m_left > 1 && m_cti != 3'b000) m_err = 1;
                if (beat_i) m_left = m_left - 1;
                if (beat_i && m_left == 0) begin
                    m_tail = 1; m_abort = 0;
                end else if (!req_i[m_owner]) begin
                    m_tail = 1; m_abort = 1;
                end
            end
            m_tick = m_tick + 1;
        end else begin
            m_win = -1;
            for (int i = 0; i < N; i++) begin
                m_p = (m_ptr + i) % N;
                if (m_win < 0 && req_i[m_p]) m_win = m_p;
            end
            if (m_win >= 0) begin
                m_owner  = m_win;
                m_active = 1;
                m_tick   = 0;
                m_adr    = adr_i[4*m_win +: 4];
                m_cti    = cti_i[3*m_win +: 3];
                m_bte    = bte_i[2*m_win +: 2];
                m_left   = beats(m_cti, m_bte, m_adr);
                m_ptr    = (m_win + 1) % N;
            end
        end
    end

    // ---------------- bookkeeping ----------------
    int           checks = 0, errors = 0;
    int           n_init = 0, n_inc = 0, n_prime_ack = 0;
    int           n_ack [N];
    bit           prev_init = 0;
    logic [N-1:0] glog [$];
    int           gen_cnt = 0, gen_len = 0;
    bit           force_en = 0, force_val = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: compare against the model mid-cycle, update monitors and the
    // generator stand-in, then return just after the next rising edge.
    task automatic cyc();
        logic [N-1:0] e_gnt, e_ack;
        bit           e_live, e_inc;
        @(negedge clk);
        e_live = m_active && !m_tail;
        e_gnt  = '0;
        if (e_live) e_gnt[m_owner] = 1'b1;
        e_inc  = e_live && (m_tick >= 2) && beat_i;
        e_ack  = e_inc ? e_gnt : '0;
        chk("gnt_o",  gnt_o,  e_gnt);
        chk("ack_o",  ack_o,  e_ack);
        chk("inc_o",  inc_o,  e_inc);
        chk("init_o", init_o, e_live && (m_tick == 0));
        chk("busy_o", busy_o, e_live);
        chk("adr_o",  adr_o,  m_adr);
        chk("cti_o",  cti_o,  m_cti);
        chk("bte_o",  bte_o,  m_bte);
        chk("err_o",  err_o,  m_err);
        if (init_o) begin
            n_init++;
            glog.push_back(gnt_o);
        end
        for (int k = 0; k < N; k++) if (ack_o[k]) n_ack[k]++;
        if (inc_o) n_inc++;
        if (prev_init && (ack_o != '0)) n_prime_ack++;
        prev_init = init_o;
        if (rst) gen_cnt = 0;
        else begin
            if (init_o) gen_cnt = 0;
            if (inc_o)  gen_cnt++;
        end
        @(posedge clk);
        #2;
        done_i = force_en ? force_val : (gen_len > 0 && gen_cnt >= gen_len);
    endtask

    task automatic set_port(input int p, input logic [3:0] a, input logic [2:0] c, input logic [1:0] b);
        adr_i[4*p +: 4] = a;
        cti_i[3*p +: 3] = c;
        bte_i[2*p +: 2] = b;
    endtask

    // Run until port p has collected n acks, then release its request.
    task automatic wait_acks(input int p, input int n, input bit drop_beat);
        int start, t;
        start = n_ack[p];
        t = 0;
        while ((n_ack[p] - start) < n && t < 300) begin
            cyc();
            t++;
        end
        if (t >= 300) chk("timeout_acks", n_ack[p] - start, n);
        req_i[p] = 1'b0;
        if (drop_beat) beat_i = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy_o && t < 100) begin
            cyc();
            t++;
        end
        if (t >= 100) chk("timeout_idle", busy_o, 0);
        cyc();
        cyc();
    endtask

    function automatic logic [N-1:0] last_gnt();
        if (glog.size() == 0) return '0;
        return glog[glog.size()-1];
    endfunction

    int i0, a0, c0, g0;
    int ab [N];

    initial begin
        for (int k = 0; k < N; k++) n_ack[k] = 0;

        // Reset state
        cyc();
        cyc();
        chk("rst_gnt",  gnt_o,  0);
        chk("rst_busy", busy_o, 0);
        chk("rst_err",  err_o,  0);
        chk("rst_adr",  adr_o,  0);
        rst = 1'b0;
        cyc();

        // Single classic cycle on port 1
        set_port(1, 4'd5, 3'b000, 2'b00);
        gen_len = 1; beat_i = 1'b1;
        i0 = n_init; a0 = n_ack[1];
        req_i[1] = 1'b1;
        wait_acks(1, 1, 0);
        wait_idle();
        chk("t1_gnt",  last_gnt(), 4'b0010);
        chk("t1_init", n_init - i0, 1);
        chk("t1_ack",  n_ack[1] - a0, 1);
        chk("t1_adr",  adr_o, 4'd5);
        chk("t1_err",  err_o, 0);

        // Wrap4 on port 0, beats offered continuously including priming
        set_port(0, 4'd6, 3'b010, 2'b01);
        gen_len = 4;
        i0 = n_init; a0 = n_ack[0]; c0 = n_inc; g0 = n_prime_ack;
        req_i[0] = 1'b1;
        wait_acks(0, 4, 0);
        wait_idle();
        chk("t2_gnt",   last_gnt(), 4'b0001);
        chk("t2_init",  n_init - i0, 1);
        chk("t2_ack",   n_ack[0] - a0, 4);
        chk("t2_inc",   n_inc - c0, 4);
        chk("t2_prime", n_prime_ack - g0, 0);
        chk("t2_busy",  busy_o, 0);
        chk("t2_err",   err_o, 0);

        // Wrap8 on port 2 abandoned after 3 beats
        set_port(2, 4'd3, 3'b010, 2'b10);
        gen_len = 8;
        a0 = n_ack[2]; c0 = n_inc;
        req_i[2] = 1'b1;
        wait_acks(2, 3, 1);
        cyc();
        chk("t5_busy", busy_o, 0);
        chk("t5_gnt",  gnt_o, 0);
        wait_idle();
        chk("t5_ack",  n_ack[2] - a0, 3);
        chk("t5_inc",  n_inc - c0, 3);
        chk("t5_err",  err_o, 0);
        beat_i = 1'b1;

        // Linear from 12 on port 3 with the generator never reporting done
        set_port(3, 4'd12, 3'b010, 2'b00);
        gen_len = 4; force_en = 1; force_val = 0;
        a0 = n_ack[3];
        req_i[3] = 1'b1;
        wait_acks(3, 4, 0);
        wait_idle();
        force_en = 0;
        chk("t4_ack", n_ack[3] - a0, 4);
        chk("t4_err", err_o, 1);

        // Wrap16 on port 1 interrupted by reset
        set_port(1, 4'd9, 3'b010, 2'b11);
        gen_len = 16;
        req_i[1] = 1'b1;
        wait_acks(1, 5, 0);
        req_i[1] = 1'b1;
        chk("t6_err_sticky", err_o, 1);
        chk("t6_busy_pre",   busy_o, 1);
        #1 rst = 1'b1;
        #1;
        chk("t6_gnt",  gnt_o, 0);
        chk("t6_ack",  ack_o, 0);
        chk("t6_inc",  inc_o, 0);
        chk("t6_init", init_o, 0);
        chk("t6_busy", busy_o, 0);
        chk("t6_err",  err_o, 0);
        chk("t6_adr",  adr_o, 0);
        chk("t6_cti",  cti_o, 0);
        chk("t6_bte",  bte_o, 0);
        req_i = '0;
        for (int k = 0; k < N; k++) set_port(k, 4'(k), 3'b000, 2'b00);
        gen_len = 1;
        cyc();

        // All ports request after reset: rotation must start at port 0
        rst = 1'b0;
        i0 = n_init; g0 = glog.size();
        for (int k = 0; k < N; k++) ab[k] = n_ack[k];
        req_i = '1;
        begin
            int t;
            t = 0;
            while (glog.size() < g0 + 5 && t < 100) begin
                cyc();
                t++;
            end
            if (t >= 100) chk("timeout_rr", glog.size() - g0, 5);
        end
        req_i = '0;
        wait_idle();
        if (glog.size() >= g0 + 5) begin
            chk("t3_g0", glog[g0],   4'b0001);
            chk("t3_g1", glog[g0+1], 4'b0010);
            chk("t3_g2", glog[g0+2], 4'b0100);
            chk("t3_g3", glog[g0+3], 4'b1000);
            chk("t3_g4", glog[g0+4], 4'b0001);
        end
        chk("t3_init", n_init - i0, 5);
        chk("t3_ack0", n_ack[0] - ab[0], 2);
        chk("t3_ack1", n_ack[1] - ab[1], 1);
        chk("t3_ack2", n_ack[2] - ab[2], 1);
        chk("t3_ack3", n_ack[3] - ab[3], 1);
        chk("t3_err",  err_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_burst_sched.md
Name: wb_burst_sched

Overview:
- Shares one burst address generator, and the SDRAM datapath it feeds, between up to four Wishbone requesters using round-robin arbitration.
- Per burst: latches the winner's adr/cti/bte, pulses the generator's init, converts datapath beat completions into inc pulses and per-port acks, and counts beats to find the burst end.
- Cross-checks the generator's done flag; a mismatch raises a sticky error.

Parameters:
- NPORTS, 4, number of requesters; legal range 2..4.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_i  in  NPORTS  per-port cycle request (cyc&stb)
- adr_i  in  4*NPORTS  packed start word addresses; port k at [4k+3:4k]
- cti_i  in  3*NPORTS  packed Wishbone cycle type identifiers
- bte_i  in  2*NPORTS  packed burst type extensions
- gnt_o  out  NPORTS  one-hot grant, held for the whole burst
- ack_o  out  NPORTS  per-port ack, one per completed beat
- adr_o  out  4  latched start address to the generator
- cti_o  out  3  latched cti to the generator
- bte_o  out  2  latched bte to the generator
- init_o  out  1  one-cycle init pulse to the generator
- inc_o  out  1  address increment to the generator
- beat_i  in  1  datapath finished one beat this cycle
- done_i  in  1  generator done flag
- busy_o  out  1  a burst is in progress
- err_o  out  1  sticky done/beat-count mismatch

Behaviour:
- Reset values: gnt_o=0, ack_o=0, adr_o=0, cti_o=0, bte_o=0, init_o=0, inc_o=0, busy_o=0, err_o=0, RR pointer=0, FSM state=IDLE, beat counter=0.
- IDLE:
  - If any req_i is high, pick the first requesting port at or after the RR pointer, wrapping modulo NPORTS.
  - Register gnt_o and latch that port's adr/cti/bte into adr_o/cti_o/bte_o.
  - Set RR pointer = winner+1 mod NPORTS. Go to INIT.
  - With no request, stay in IDLE and hold all outputs.
- INIT: init_o=1 for exactly this cycle; busy_o=1; load the beat counter. Next state PRIME.
- Beat count (5-bit counter):
  - cti 000 or 111: 1 beat.
  - Otherwise bte 01: 4 beats; bte 10: 8 beats; bte 11: 16 beats.
  - Otherwise bte 00 (linear): 16-adr beats; adr=0 gives 16.
- PRIME: one idle cycle to cover the generator's internal one-cycle init delay; no inc or ack is issued. Next state BURST.
- BURST:
  - inc_o = beat_i and ack_o[g] = beat_i, both combinational from beat_i while the grant is held.
  - Each beat decrements the counter. The beat that brings it to 0 moves to DONE.
  - If req_i[g] drops with no beat that cycle: abort to DONE. No further ack or inc is issued and err_o is not checked.
- DONE:
  - gnt_o=0, busy_o=0.
  - For a normal (non-aborted) end, sample done_i here, the cycle after the last inc; done_i=0 sets err_o.
  - done_i is also checked in BURST: done_i=1 while the counter is above 1 and the latched cti is not 000 sets err_o.
  - Next state IDLE. Back-to-back arbitration is therefore possible with a minimum 1-cycle gap.
- Simultaneous events:
  - Requests from new ports during a burst are ignored until IDLE.
  - beat_i outside BURST is ignored; no ack or inc is produced.
  - beat_i on the same cycle req_i[g] drops still completes that beat: ack_o and inc_o are asserted, then the FSM goes to DONE.
- err_o clears only on rst.
- Reset mid-burst: everything returns to reset values immediately. The generator is reset by the same rst.

Decomposition:
- Shared package constants: CTI_CLASSIC=000, CTI_INCR=010, CTI_EOB=111, BTE_LINEAR=00, BTE_WRAP4=01, BTE_WRAP8=10, BTE_WRAP16=11, and the FSM state encoding {IDLE, INIT, PRIME, BURST, DONE}.
- One sub-module, rr_arbiter: NPORTS request vector plus pointer in, one-hot grant out; purely combinational, with the pointer register kept in the top level.

Test Plan:
- Single port 1, adr=5, cti=000, bte=00 -> gnt_o=0010; init_o high one cycle; with one beat_i, ack_o[1] pulses once; DONE with done_i=1; err_o=0.
- Port 0, adr=6, cti=010, bte=01, done_i modelled correctly -> exactly 4 inc/ack pulses, no ack during PRIME, return to IDLE.
- Ports 0..3 request continuously -> grants in order 0,1,2,3,0; each burst is preceded by one init pulse.
- Linear burst, adr=12, cti=010, bte=00 -> 4 beats; done_i forced low at DONE -> err_o=1 and remains 1 until rst.
- Port 2 wrap8 drops req after 3 beats -> DONE, no further ack, busy_o=0 next cycle, err_o unchanged.
- rst asserted during BURST of a wrap16 -> all outputs return to 0 asynchronously; a new request after release gets an init pulse; RR pointer=0.
